// File: rtl/spi_dac_out.sv
// spi_dac_out: accepts one PCM sample per valid/ready handshake and shifts it as a
// 16-bit SYNC-framed write to a serial DAC that latches data on falling SCLK.
module spi_dac_out #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample,
    input  logic [1:0]        pd_mode,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              spi_clk,
    output logic              spi_mosi,
    output logic              spi_cs,
    output logic              busy,
    output logic              frame_done
);
    localparam int DW = $clog2(2 * CLK_DIV);
    localparam logic [DW-1:0] PH_END   = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HOLD_END = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] FD_AT    = DW'(2 * CLK_DIV - 2);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t      state, state_n;
    logic [DW-1:0] div, div_n;
    logic [3:0]  bit_cnt, bit_n;
    logic [15:0] sreg, sreg_n;
    logic        ready_n, sclk_n, mosi_n, cs_n, busy_n, fd_n;
    logic [11:0] field;
    logic [15:0] word;

    assign field = 12'(sample) << (12 - DATA_W);
    assign word  = {2'b00, pd_mode, field};

    always_comb begin
        state_n = state;
        div_n   = div;
        bit_n   = bit_cnt;
        sreg_n  = sreg;
        ready_n = sample_ready;
        sclk_n  = spi_clk;
        mosi_n  = spi_mosi;
        cs_n    = spi_cs;
        busy_n  = busy;
        fd_n    = 1'b0;
        case (state)
            IDLE: begin
                ready_n = 1'b1;
                if (sample_valid && sample_ready) begin
                    state_n = SETUP;
                    div_n   = '0;
                    sreg_n  = word;
                    ready_n = 1'b0;
                    busy_n  = 1'b1;
                    cs_n    = 1'b0;
                    mosi_n  = word[15];
                end
            end
            SETUP: begin
                if (div == PH_END) begin
                    state_n = SHIFT;
                    div_n   = '0;
                    bit_n   = '0;
                    sclk_n  = 1'b0;
                end else div_n = div + 1'b1;
            end
            SHIFT: begin
                if (div != PH_END) div_n = div + 1'b1;
                else begin
                    div_n = '0;
                    // data only moves on the rising SCLK edge, far from the DAC's sampling edge
                    if (!spi_clk) begin
                        sclk_n = 1'b1;
                        if (bit_cnt != 4'd15) begin
                            sreg_n = {sreg[14:0], 1'b0};
                            mosi_n = sreg[14];
                        end
                    end else if (bit_cnt == 4'd15) begin
                        state_n = HOLD;
                        cs_n    = 1'b1;
                        mosi_n  = 1'b0;
                    end else begin
                        sclk_n = 1'b0;
                        bit_n  = bit_cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                fd_n = (div == FD_AT);
                if (div == HOLD_END) begin
                    state_n = IDLE;
                    div_n   = '0;
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                end else div_n = div + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            div          <= '0;
            bit_cnt      <= '0;
            sreg         <= '0;
            sample_ready <= 1'b0;
            spi_clk      <= 1'b1;
            spi_mosi     <= 1'b0;
            spi_cs       <= 1'b1;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_n;
            div          <= div_n;
            bit_cnt      <= bit_n;
            sreg         <= sreg_n;
            sample_ready <= ready_n;
            spi_clk      <= sclk_n;
            spi_mosi     <= mosi_n;
            spi_cs       <= cs_n;
            busy         <= busy_n;
            frame_done   <= fd_n;
        end
    end
endmodule

// File: tb/tb_spi_dac_out.sv
// tb_spi_dac_out: scoreboard bench; expected words queued at accept, compared when
// the DAC-side monitor sees SYNC rise after a frame.
module tb_spi_dac_out;
    logic        clk = 1'b0, rst = 1'b0;
    logic [11:0] sample = '0;
    logic [1:0]  pd_mode = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready, spi_clk, spi_mosi, spi_cs, busy, frame_done;
    logic [9:0]  sample10 = '0;
    logic [1:0]  pd10 = '0;
    logic        valid10 = 1'b0;
    logic        ready10, spi_clk10, spi_mosi10, spi_cs10, busy10, done10;

    spi_dac_out #(.CLK_DIV(4), .DATA_W(12)) u_dut (
        .clk(clk), .rst(rst), .sample(sample), .pd_mode(pd_mode),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_cs(spi_cs), .busy(busy), .frame_done(frame_done));

    spi_dac_out #(.CLK_DIV(4), .DATA_W(10)) u_dut10 (
        .clk(clk), .rst(rst), .sample(sample10), .pd_mode(pd10),
        .sample_valid(valid10), .sample_ready(ready10), .spi_clk(spi_clk10),
        .spi_mosi(spi_mosi10), .spi_cs(spi_cs10), .busy(busy10), .frame_done(done10));

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [15:0] exp_q[$];
    logic [15:0] cap = '0;
    int nbits = 0, cs_low = 0, gap = 0, last_gap = 0, fd_cnt = 0, frames = 0, low_cnt = 0;
    bit acc_pending = 0, has_prev = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // DAC-side monitor; inputs are driven just after posedge, so valid&ready seen here means accept at the next edge
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            nbits = 0; cs_low = 0; gap = 0; acc_pending = 0; has_prev = 0;
            prev_cs = 1'b1; prev_sclk = 1'b1; prev_mosi = 1'b0;
        end else begin
            if (acc_pending) begin
                if (!sample_ready) low_cnt++;
                else begin
                    chk("ready_low", low_cnt, 140);
                    acc_pending = 0;
                end
            end
            if (sample_valid && sample_ready) begin
                exp_q.push_back({2'b00, pd_mode, sample});
                acc_pending = 1;
                low_cnt = 0;
            end
            if (prev_sclk && !spi_clk) begin
                chk("sclk_fall_cs", spi_cs, 0);
                chk("mosi_at_fall", spi_mosi, prev_mosi);
                cap = {cap[14:0], spi_mosi};
                nbits++;
            end
            if (spi_cs && !prev_cs) begin
                chk("frame_bits", nbits, 16);
                chk("cs_low", cs_low, 132);
                if (exp_q.size() == 0) chk("unexpected_frame", cap, 32'hFFFF_FFFF);
                else chk("frame_word", cap, exp_q.pop_front());
                frames++;
                has_prev = 1;
                gap = 0; nbits = 0; cs_low = 0;
            end
            if (spi_cs) gap++;
            else begin
                if (prev_cs && has_prev) begin
                    last_gap = gap;
                    chk("cs_gap_min", gap >= 8, 1);
                end
                cs_low++;
            end
            if (frame_done) begin
                fd_cnt++;
                chk("fd_pos", gap, 8);
            end
            prev_cs = spi_cs; prev_sclk = spi_clk; prev_mosi = spi_mosi;
        end
    end

    task automatic send(input logic [11:0] s, input logic [1:0] p);
        int n = 0;
        sample = s; pd_mode = p; sample_valid = 1'b1;
        while (!sample_ready && n < 400) begin
            @(posedge clk); #1; n++;
        end
        if (!sample_ready) chk("accept_timeout", 0, 1);
        else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !sample_ready || busy) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk("idle_timeout", n < 2000, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1);
    end

    initial begin
        int f0, fr0, n, nb;
        logic [15:0] w10;
        logic ps;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", spi_cs, 1);
        chk("rst_sclk", spi_clk, 1);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_ready", sample_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fd", frame_done, 0);
        rst = 1'b1;
        #1 chk("ready_pre_edge", sample_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_rst", sample_ready, 1);
        chk("busy_after_rst", busy, 0);

        f0 = fd_cnt; fr0 = frames;
        send(12'hA5C, 2'b00);
        sample_valid = 1'b0;
        sample = 12'h000;
        chk("t2_busy", busy, 1);
        chk("t2_cs", spi_cs, 0);
        wait_idle();
        chk("t2_fd", fd_cnt - f0, 1);
        chk("t2_frames", frames - fr0, 1);

        n = 0;
        while (!ready10 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        sample10 = 10'h3FF; pd10 = 2'b11; valid10 = 1'b1;
        @(posedge clk); #1;
        valid10 = 1'b0;
        nb = 0; ps = 1'b1; w10 = '0;
        for (int i = 0; i < 400 && nb < 16; i++) begin
            @(negedge clk);
            if (ps && !spi_clk10) begin
                w10 = {w10[14:0], spi_mosi10};
                nb++;
            end
            ps = spi_clk10;
        end
        chk("t3_bits", nb, 16);
        chk("t3_word", w10, 16'h3FFC);

        f0 = fd_cnt; fr0 = frames;
        send(12'h001, 2'b00);
        send(12'hFFF, 2'b00);
        sample_valid = 1'b0;
        wait_idle();
        chk("t4_frames", frames - fr0, 2);
        chk("t4_gap", last_gap, 9);

        f0 = fd_cnt; fr0 = frames;
        send(12'h5A3, 2'b01);
        sample_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            repeat (20) @(posedge clk);
            #1;
            sample = 12'($urandom); pd_mode = 2'($urandom); sample_valid = 1'b1;
            @(posedge clk); #1;
            sample_valid = 1'b0;
        end
        wait_idle();
        chk("t5_fd", fd_cnt - f0, 1);
        chk("t5_frames", frames - fr0, 1);

        send(12'hABC, 2'b00);
        sample_valid = 1'b0;
        n = 0;
        while (nbits < 7 && n < 300) begin
            @(negedge clk); n++;
        end
        chk("t6_reach7", nbits >= 7, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_cs", spi_cs, 1);
        chk("t6_sclk", spi_clk, 1);
        chk("t6_ready", sample_ready, 0);
        chk("t6_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        f0 = fd_cnt; fr0 = frames;
        send(12'h123, 2'b00);
        sample_valid = 1'b0;
        wait_idle();
        chk("t6_frames", frames - fr0, 1);
        chk("t6_fd", fd_cnt - f0, 1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
